// File: rtl/poseidon_stream_pkg.sv
// Shared state encoding and default sizing for the Poseidon packet streamer and its bench.
package poseidon_stream_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int DEF_WIDTH   = 255;
  localparam int DEF_ELEMS   = 3;
  localparam int DEF_DEPTH   = 8;
  localparam int DEF_CNT_W   = 16;
  localparam int DEF_TIMEOUT = 4096;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO: a write is visible on rd_data the next cycle.
// Writes when full and reads when empty are dropped; full never credits a same-cycle read.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST_SLOT = AW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_wr;
  logic             do_rd;

  // Slot index wraps at DEPTH-1 so non-power-of-two depths work; the top bit tracks laps.
  function automatic logic [AW:0] bump(input logic [AW:0] p);
    if (p[AW-1:0] == LAST_SLOT) return {~p[AW], {AW{1'b0}}};
    return {p[AW], p[AW-1:0] + 1'b1};
  endfunction

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= bump(wr_ptr);
      if (do_rd) rd_ptr <= bump(rd_ptr);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/poseidon_packet_streamer.sv
// Buffers host elements, streams them to the hash core as ELEMS-beat packets and checks every digest.
// Input beats are FWFT from the buffer and held stable under backpressure; counters update one cycle after their event.
module poseidon_packet_streamer
  import poseidon_stream_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int ELEMS   = DEF_ELEMS,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_payload,
  input  logic             start,
  input  logic [CNT_W-1:0] pkt_target,
  input  logic [WIDTH-1:0] exp_payload,
  output logic             io_input_valid,
  input  logic             io_input_ready,
  output logic             io_input_last,
  output logic [WIDTH-1:0] io_input_payload,
  input  logic             io_output_valid,
  output logic             io_output_ready,
  input  logic             io_output_last,
  input  logic [WIDTH-1:0] io_output_payload,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [CNT_W-1:0] sent_cnt,
  output logic [CNT_W-1:0] recv_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] first_err_idx
);
  localparam int IDX_W = (ELEMS > 1) ? $clog2(ELEMS) : 1;
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] target;
  logic [WIDTH-1:0] exp_dat;
  logic [IDX_W-1:0] elem_idx;
  logic [TO_W-1:0]  idle_cnt;
  logic [WIDTH-1:0] fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             start_ok;
  logic             in_hs;
  logic             in_last;
  logic             out_hs;
  logic             out_err;
  logic             final_beat;
  logic             idle_hit;
  logic             timeout_set;
  logic [CNT_W-1:0] sent_nxt;
  logic [CNT_W-1:0] recv_nxt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH * ELEMS)
  ) u_buf (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (load_valid),
    .wr_data (load_payload),
    .rd_en   (in_hs),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign load_ready       = !fifo_full;
  assign busy             = (state == ST_SEND) || (state == ST_DRAIN);
  assign done             = (state == ST_DONE);
  assign pass             = done && (err_cnt == '0) && (recv_cnt == target) && !timeout;
  assign io_output_ready  = busy;
  assign io_input_valid   = (state == ST_SEND) && !fifo_empty;
  assign io_input_last    = (state == ST_SEND) && in_last;
  assign io_input_payload = io_input_valid ? fifo_head : '0;

  assign start_ok   = start && !busy;
  assign in_last    = (elem_idx == IDX_W'(ELEMS - 1));
  assign in_hs      = io_input_valid && io_input_ready;
  assign out_hs     = io_output_valid && io_output_ready;
  assign out_err    = out_hs && ((io_output_payload != exp_dat) || !io_output_last);
  assign sent_nxt   = (in_hs && in_last) ? sat_inc(sent_cnt) : sent_cnt;
  assign recv_nxt   = out_hs ? sat_inc(recv_cnt) : recv_cnt;
  assign final_beat = in_hs && in_last && (sent_nxt == target);
  assign idle_hit   = (idle_cnt + 1'b1) == TO_W'(TIMEOUT);

  always_comb begin
    state_nxt   = state;
    timeout_set = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) state_nxt = (pkt_target == '0) ? ST_DONE : ST_SEND;
      end
      ST_SEND: begin
        // Results may already be in if the core pipelines; skip DRAIN then.
        if (final_beat) state_nxt = (recv_nxt >= target) ? ST_DONE : ST_DRAIN;
      end
      ST_DRAIN: begin
        if (recv_nxt >= target) begin
          state_nxt = ST_DONE;
        end else if (!out_hs && idle_hit) begin
          state_nxt   = ST_DONE;
          timeout_set = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      target        <= '0;
      exp_dat       <= '0;
      elem_idx      <= '0;
      idle_cnt      <= '0;
      sent_cnt      <= '0;
      recv_cnt      <= '0;
      err_cnt       <= '0;
      first_err_idx <= '0;
      timeout       <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start_ok) begin
        target        <= pkt_target;
        exp_dat       <= exp_payload;
        elem_idx      <= '0;
        sent_cnt      <= '0;
        recv_cnt      <= '0;
        err_cnt       <= '0;
        first_err_idx <= '0;
        timeout       <= 1'b0;
      end else begin
        if (in_hs) elem_idx <= in_last ? '0 : elem_idx + 1'b1;
        sent_cnt <= sent_nxt;
        recv_cnt <= recv_nxt;
        if (out_err) err_cnt <= sat_inc(err_cnt);
        // err_cnt saturates rather than wraps, so zero reliably means no error yet.
        if (out_err && (err_cnt == '0)) first_err_idx <= recv_cnt;
        if (timeout_set) timeout <= 1'b1;
      end
      if ((state != ST_DRAIN) || out_hs) idle_cnt <= '0;
      else idle_cnt <= idle_cnt + 1'b1;
    end
  end

endmodule
